break_value_generator: RTL and testbench

BREAK_VALUE_GENERATOR -- requirements
Module: break_value_generator

---
 rtl/break_value_generator.sv | 186 ++++++++++++++++++
 tb/tb_break_value_generator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/break_value_generator.sv
// WalkSAT break-value generator: walks each literal's occurrence list, counts critical clauses,
// presents the counts to a selector and issues the chosen flip. Optional tabu masking: BVG_TABU_EN.

module bvg_lit_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         add,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   count <= '0;
      else if (clear)               count <= '0;
      else if (add && count != '1)  count <= count + W'(1);
   end
endmodule

module break_value_generator #(
   parameter int NSAT                          = 3,
   parameter int NSAT_BITS                     = 2,
   parameter int MAX_CLAUSES_PER_VARIABLE      = 20,
   parameter int MAX_CLAUSES_PER_VARIABLE_BITS = 5,
   parameter int VAR_BITS                      = 16
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      clause_valid_i,
   output logic                                      clause_ready_o,
   input  logic [NSAT*VAR_BITS-1:0]                  clause_vars_i,
   input  logic [NSAT-1:0]                           clause_lit_valid_i,
   output logic                                      occ_req_o,
   output logic [VAR_BITS-1:0]                       occ_var_o,
   output logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0]  occ_idx_o,
   input  logic                                      occ_rsp_valid_i,
   input  logic                                      occ_rsp_end_i,
   input  logic                                      occ_rsp_critical_i,
   output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_values_o,
   output logic [NSAT-1:0]                           break_values_valid_o,
   input  logic [NSAT_BITS-1:0]                      select_i,
   input  logic                                      random_selection_i,
   output logic                                      flip_valid_o,
   input  logic                                      flip_ready_i,
   output logic [VAR_BITS-1:0]                       flip_var_o,
   output logic                                      flip_random_o,
   output logic                                      flip_none_o
);
   localparam int MB = MAX_CLAUSES_PER_VARIABLE_BITS;
   localparam int LW = $clog2(NSAT + 1);
   localparam logic [MB-1:0] LAST_IDX = MB'(MAX_CLAUSES_PER_VARIABLE - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, SELECT, FLIP} state_t;
   state_t state, state_next;

   logic [VAR_BITS-1:0]       vars_q [NSAT];
   logic [NSAT-1:0]           lit_valid_q, present_valid, add;
   logic [NSAT-1:0][MB-1:0]   counts;
   logic [LW-1:0]             lit_q;
   logic [MB-1:0]             idx_q;
   logic [VAR_BITS-1:0]       flip_var_q, cur_var;
   logic                      ready_en, flip_none_q, flip_random_q;
   logic                      accept, lit_in, cur_valid, sel_ok, rsp, presenting;

   assign accept     = clause_valid_i && clause_ready_o;
   assign lit_in     = int'(lit_q) < NSAT;
   assign cur_valid  = lit_in && lit_valid_q[lit_q];
   assign cur_var    = lit_in ? vars_q[lit_q] : '0;
   assign rsp        = (state == WAIT) && occ_rsp_valid_i;
   assign presenting = (state == PRESENT) || (state == SELECT);
   assign sel_ok     = (int'(select_i) < NSAT) && present_valid[select_i];

   for (genvar i = 0; i < NSAT; i++) begin : g_lane
      assign add[i] = rsp && !occ_rsp_end_i && occ_rsp_critical_i && (lit_q == LW'(i));
      bvg_lit_counter #(.W(MB)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clear (accept),
         .add   (add[i]),
         .count (counts[i])
      );
   end

`ifdef BVG_TABU_EN
   logic                tabu_set;
   logic [VAR_BITS-1:0] tabu_var;
   logic [NSAT-1:0]     masked;

   always_comb begin
      masked = lit_valid_q;
      for (int i = 0; i < NSAT; i++)
         if (tabu_set && vars_q[i] == tabu_var) masked[i] = 1'b0;
      // never mask away the last remaining candidate
      present_valid = (masked != '0) ? masked : lit_valid_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tabu_set <= 1'b0;
         tabu_var <= '0;
      end else if (state == FLIP && flip_ready_i) begin
         tabu_set <= 1'b1;
         tabu_var <= flip_var_q;
      end
   end
`else
   assign present_valid = lit_valid_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (clause_lit_valid_i == '0) ? PRESENT : FETCH;
         FETCH:   if (!lit_in) state_next = PRESENT;
                  else if (cur_valid) state_next = WAIT;
         WAIT:    if (occ_rsp_valid_i) state_next = FETCH;
         PRESENT: state_next = SELECT;
         SELECT:  state_next = sel_ok ? FLIP : IDLE;
         FLIP:    if (flip_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSAT; i++) vars_q[i] <= '0;
         lit_valid_q   <= '0;
         lit_q         <= '0;
         idx_q         <= '0;
         ready_en      <= 1'b0;
         flip_none_q   <= 1'b0;
         flip_var_q    <= '0;
         flip_random_q <= 1'b0;
      end else begin
         ready_en    <= 1'b1;
         flip_none_q <= (state == SELECT) && !sel_ok;
         case (state)
            IDLE: if (accept) begin
               for (int i = 0; i < NSAT; i++) vars_q[i] <= clause_vars_i[i*VAR_BITS +: VAR_BITS];
               lit_valid_q <= clause_lit_valid_i;
               lit_q       <= '0;
               idx_q       <= '0;
            end
            FETCH: if (lit_in && !cur_valid) lit_q <= lit_q + LW'(1);
            WAIT: if (occ_rsp_valid_i) begin
               // list ends on an empty entry or when the table row is exhausted
               if (occ_rsp_end_i || idx_q == LAST_IDX) begin
                  lit_q <= lit_q + LW'(1);
                  idx_q <= '0;
               end else begin
                  idx_q <= idx_q + MB'(1);
               end
            end
            SELECT: if (sel_ok) begin
               flip_var_q    <= vars_q[select_i];
               flip_random_q <= random_selection_i;
            end
            default: ;
         endcase
      end
   end

   assign clause_ready_o = (state == IDLE) && ready_en;
   assign occ_req_o      = (state == FETCH) && cur_valid;
   assign occ_var_o      = (occ_req_o || state == WAIT) ? cur_var : '0;
   assign occ_idx_o      = (occ_req_o || state == WAIT) ? idx_q : '0;

   always_comb begin
      break_values_o       = '0;
      break_values_valid_o = '0;
      if (presenting) begin
         for (int i = 0; i < NSAT; i++) break_values_o[i*MB +: MB] = counts[i];
         break_values_valid_o = present_valid;
      end
   end

   assign flip_valid_o  = (state == FLIP);
   assign flip_var_o    = flip_valid_o ? flip_var_q : '0;
   assign flip_random_o = flip_valid_o && flip_random_q;
   assign flip_none_o   = flip_none_q;
endmodule

// File: tb/tb_break_value_generator.sv
// Randomized + directed bench for break_value_generator against a list-level reference model.
// Define BVG_TABU_EN to also check the tabu masking.

module tb_break_value_generator;
   localparam int NSAT = 3, NB = 2, MAXC = 20, MB = 5, VB = 16;

   logic                 clk = 1'b0, reset = 1'b0;
   logic                 clause_valid_i = 0, clause_ready_o;
   logic [NSAT*VB-1:0]   clause_vars_i = '0;
   logic [NSAT-1:0]      clause_lit_valid_i = '0;
   logic                 occ_req_o;
   logic [VB-1:0]        occ_var_o;
   logic [MB-1:0]        occ_idx_o;
   logic                 occ_rsp_valid_i = 0, occ_rsp_end_i = 0, occ_rsp_critical_i = 0;
   logic [NSAT*MB-1:0]   break_values_o;
   logic [NSAT-1:0]      break_values_valid_o;
   logic [NB-1:0]        select_i = '0;
   logic                 random_selection_i = 0;
   logic                 flip_valid_o, flip_ready_i = 0;
   logic [VB-1:0]        flip_var_o;
   logic                 flip_random_o, flip_none_o;

   break_value_generator dut (
      .clk(clk), .reset(reset),
      .clause_valid_i(clause_valid_i), .clause_ready_o(clause_ready_o),
      .clause_vars_i(clause_vars_i), .clause_lit_valid_i(clause_lit_valid_i),
      .occ_req_o(occ_req_o), .occ_var_o(occ_var_o), .occ_idx_o(occ_idx_o),
      .occ_rsp_valid_i(occ_rsp_valid_i), .occ_rsp_end_i(occ_rsp_end_i),
      .occ_rsp_critical_i(occ_rsp_critical_i),
      .break_values_o(break_values_o), .break_values_valid_o(break_values_valid_o),
      .select_i(select_i), .random_selection_i(random_selection_i),
      .flip_valid_o(flip_valid_o), .flip_ready_i(flip_ready_i),
      .flip_var_o(flip_var_o), .flip_random_o(flip_random_o), .flip_none_o(flip_none_o)
   );

   always #5 clk = ~clk;

   int passes = 0, checks = 0;
   bit          tabu_set = 0;
   logic [VB-1:0] tabu_var = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Issue one clause and serve the occurrence table from per-literal lists:
   // len[i] non-end entries (critical bits in crit[i]) followed by an end entry.
   task automatic run_clause(input logic [VB-1:0] v0, v1, v2, input logic [2:0] lv,
                             input int l0, l1, l2, input logic [24:0] c0, c1, c2,
                             input logic [1:0] sel, input bit rnd, input int hold);
      logic [VB-1:0] vars [3];
      int            len  [3];
      logic [24:0]   crit [3];
      int            qlit[$], qidx[$];
      logic [2:0]    vexp, masked;
      logic [14:0]   bexp;
      logic [VB-1:0] exp_var;
      logic [4:0]    ci;
      bit            exp_none, pend, captured, done;
      int            dly, cl, b;
      vars = '{v0, v1, v2}; len = '{l0, l1, l2}; crit = '{c0, c1, c2};
      bexp = '0;
      for (int i = 0; i < 3; i++) if (lv[i]) begin
         b = 0;
         for (int k = 0; k < ((len[i] + 1 < MAXC) ? len[i] + 1 : MAXC); k++) begin
            qlit.push_back(i); qidx.push_back(k);
            if (k < len[i]) b += int'(crit[i][k]);
         end
         bexp[i*MB +: MB] = MB'(b > 31 ? 31 : b);
      end
      masked = lv;
      for (int i = 0; i < 3; i++) if (tabu_set && vars[i] == tabu_var) masked[i] = 1'b0;
`ifdef BVG_TABU_EN
      vexp = (masked != 0) ? masked : lv;
`else
      vexp = lv;
`endif
      exp_none = (sel >= 3) || !vexp[sel];
      exp_var  = (sel < 3) ? vars[sel] : '0;

      @(negedge clk);
      select_i = sel; random_selection_i = rnd;
      clause_vars_i = {v2, v1, v0}; clause_lit_valid_i = lv; clause_valid_i = 1;
      check("accept_ready", clause_ready_o, 1);
      pend = 0; captured = 0; done = 0; dly = 0; cl = 0; ci = '0;
      for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
         @(negedge clk);
         clause_valid_i = 0; occ_rsp_valid_i = 0;
         if (occ_req_o) begin
            check("req_expected", (qlit.size() > 0) && !pend, 1);
            if (qlit.size() > 0) begin
               cl = qlit.pop_front(); ci = 5'(qidx.pop_front());
               check("req_var_idx", {occ_var_o, occ_idx_o}, {vars[cl], ci});
               pend = 1; dly = $urandom_range(0, 2);
            end
         end else if (pend) begin
            if (dly == 0) begin
               check("wait_hold", {occ_var_o, occ_idx_o}, {vars[cl], ci});
               occ_rsp_valid_i    = 1;
               occ_rsp_end_i      = (int'(ci) >= len[cl]);
               occ_rsp_critical_i = occ_rsp_end_i ? 1'b1 : crit[cl][ci];
               pend = 0;
            end else dly--;
         end
         if (break_values_valid_o != 0) begin
            if (!captured) begin
               check("fetch_complete", qlit.size(), 0);
               check("break_valid", break_values_valid_o, vexp);
            end
            check("break_values", break_values_o, bexp);
            captured = 1;
         end
         if (flip_none_o) begin
            check("outcome_none", 1, exp_none);
            check("none_ready", clause_ready_o, 1);
            @(negedge clk);
            check("none_pulse", flip_none_o, 0);
            done = 1;
         end else if (flip_valid_o) begin
            check("outcome_none", 0, exp_none);
            check("flip_data", {flip_var_o, flip_random_o}, {exp_var, rnd});
            repeat (hold) begin
               @(negedge clk);
               check("flip_hold", {flip_valid_o, flip_var_o, flip_random_o}, {1'b1, exp_var, rnd});
            end
            flip_ready_i = 1;
            @(negedge clk);
            flip_ready_i = 0;
            check("flip_done", {flip_valid_o, clause_ready_o}, 2'b01);
            tabu_set = 1; tabu_var = exp_var;
            done = 1;
         end
      end
      occ_rsp_valid_i = 0;
      check("clause_finished", done, 1);
      check("presented", captured, lv != 0);
   endtask

   initial begin
      #1;
      check("reset_outputs", {clause_ready_o, occ_req_o, occ_var_o, occ_idx_o, break_values_o,
                              break_values_valid_o, flip_valid_o, flip_var_o, flip_random_o, flip_none_o}, 0);
      @(negedge clk); reset = 1;
      @(negedge clk);
      check("ready_after_reset", clause_ready_o, 1);

      // breaks {2,0,1}, select 1 -> flip 9, flip_ready held low 4 cycles
      run_clause(5, 9, 12, 3'b111, 3, 2, 4, 25'b011, 25'b0, 25'b0100, 1, 0, 4);
      // tabu on 9: {9,4,7} masks literal 0; then {9} alone stays valid
      run_clause(9, 4, 7, 3'b111, 1, 0, 2, 25'b1, 25'b0, 25'b11, 0, 1, 0);
      run_clause(9, 0, 0, 3'b001, 2, 0, 0, 25'b10, 25'b0, 25'b0, 0, 0, 1);
      // saturation of the list walk at 20 entries, then an immediately empty list
      run_clause(100, 200, 300, 3'b111, 25, 0, 0, '1, 25'b0, 25'b0, 0, 0, 0);
      run_clause(100, 200, 300, 3'b111, 0, 1, 0, '1, 25'b1, 25'b0, 0, 1, 0);
      // no literals present, and an out-of-range selection
      run_clause(1, 2, 3, 3'b000, 0, 0, 0, 25'b0, 25'b0, 25'b0, 0, 0, 0);
      run_clause(1, 2, 3, 3'b111, 1, 1, 1, 25'b1, 25'b1, 25'b1, 3, 0, 0);

      // reset in the middle of a WAIT, then a stale response
      @(negedge clk);
      clause_vars_i = {16'd3, 16'd2, 16'd1}; clause_lit_valid_i = 3'b111; clause_valid_i = 1;
      @(negedge clk); clause_valid_i = 0;
      check("midwait_req", occ_req_o, 1);
      @(negedge clk);
      reset = 0; #1;
      check("midwait_reset_out", {clause_ready_o, occ_req_o, occ_var_o, occ_idx_o,
                                  break_values_valid_o, flip_valid_o, flip_none_o}, 0);
      tabu_set = 0; tabu_var = '0;
      @(negedge clk); reset = 1;
      @(negedge clk);
      occ_rsp_valid_i = 1; occ_rsp_end_i = 0; occ_rsp_critical_i = 1;
      @(negedge clk); occ_rsp_valid_i = 0;
      check("late_rsp_ignored", {clause_ready_o, occ_req_o, break_values_valid_o, flip_none_o}, 6'b100000);

      for (int n = 0; n < 20; n++)
         run_clause(VB'($urandom_range(0, 5)), VB'($urandom_range(0, 5)), VB'($urandom_range(0, 5)),
                    3'($urandom), $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24),
                    25'($urandom), 25'($urandom), 25'($urandom),
                    2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
